// File: rtl/fault_campaign_ctrl.sv
// Fault-injection campaign sequencer: runs one golden pass, then walks every
// single fault (bit location x {stuck-0, stuck-1, flip}) one cycle each, and
// builds a per-fault detection map plus a detection count.
module fault_campaign_ctrl #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 4,
  parameter int unsigned LOC_W = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [A_W-1:0]                        a_in,
  input  logic [B_W-1:0]                        b_in,
  output logic [A_W-1:0]                        dut_a,
  output logic [B_W-1:0]                        dut_b,
  output logic [LOC_W-1:0]                      f_loc,
  output logic [1:0]                            f_type,
  input  logic [A_W-1:0]                        dut_c,
  input  logic [A_W-1:0]                        dut_y,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err,
  output logic [A_W-1:0]                        golden_c,
  output logic [A_W-1:0]                        golden_y,
  output logic [3*(2**LOC_W)-1:0]               detect_map,
  output logic [$clog2(3*(2**LOC_W)+1)-1:0]     detect_cnt
);

  localparam int unsigned N_LOC = 2 ** LOC_W;
  localparam int unsigned NF    = 3 * N_LOC;
  localparam int unsigned CNT_W = $clog2(NF + 1);
  localparam int unsigned K_W   = $clog2(NF);

  localparam logic [1:0] FT_NONE  = 2'b00;
  localparam logic [1:0] FT_STUCK0 = 2'b01;
  localparam logic [1:0] FT_FLIP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOLD  = 2'd1,
    S_FAULT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [K_W-1:0] k;
  logic           fault_hit;

  // Current fault changed either stage output relative to the golden pass.
  assign fault_hit = (dut_c != golden_c) || (dut_y != golden_y);

  // Campaign sequencer; every output is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      k          <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      f_loc      <= '0;
      f_type     <= FT_NONE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      golden_c   <= '0;
      golden_y   <= '0;
      detect_map <= '0;
      detect_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            detect_map <= '0;
            detect_cnt <= '0;
            f_loc      <= '0;
            f_type     <= FT_NONE;
            k          <= '0;
            if (a_in != '0) begin
              dut_a <= a_in;
              dut_b <= b_in;
              err   <= 1'b0;
              busy  <= 1'b1;
              state <= S_GOLD;
            end else begin
              // Zero modulus: abort without sweeping the stage.
              err      <= 1'b1;
              golden_c <= '0;
              golden_y <= '0;
              done     <= 1'b1;
              state    <= S_DONE;
            end
          end
        end

        S_GOLD: begin
          golden_c <= dut_c;
          golden_y <= dut_y;
          f_loc    <= '0;
          f_type   <= FT_STUCK0;
          k        <= '0;
          state    <= S_FAULT;
        end

        S_FAULT: begin
          detect_map[k] <= fault_hit;
          detect_cnt    <= detect_cnt + CNT_W'(fault_hit);
          if (k == K_W'(NF - 1)) begin
            f_loc  <= '0;
            f_type <= FT_NONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= S_DONE;
          end else begin
            k <= k + K_W'(1);
            // Types cycle 01->10->11 within a location, then move to the next bit.
            if (f_type == FT_FLIP) begin
              f_type <= FT_STUCK0;
              f_loc  <= f_loc + LOC_W'(1);
            end else begin
              f_type <= f_type + 2'd1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
